// File: rtl/usr_pkg.sv
// Shared types and helpers for the universal shift register.
package usr_pkg;

   typedef enum logic [2:0] {
      HOLD  = 3'b000,
      SHL   = 3'b001,
      SHR   = 3'b010,
      ROL   = 3'b011,
      ROR   = 3'b100,
      LOAD  = 3'b101,
      ASR   = 3'b110,
      CLEAR = 3'b111
   } shift_mode_e;

   typedef enum logic {
      S_IDLE  = 1'b0,
      S_BURST = 1'b1
   } usr_state_e;

   function automatic logic is_shift_mode(shift_mode_e m);
      return (m == SHL) || (m == SHR) || (m == ROL) || (m == ROR) || (m == ASR);
   endfunction

endpackage

// File: rtl/usr_next_val.sv
// Combinational next-value and shift-out strobes for one register operation.
module usr_next_val
   import usr_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] r,
   input  shift_mode_e      mode,
   input  logic             sl,
   input  logic             sr,
   input  logic [WIDTH-1:0] load,
   output logic [WIDTH-1:0] nxt,
   output logic             msb_we,
   output logic             lsb_we
);

   always_comb begin
      nxt    = r;
      msb_we = 1'b0;
      lsb_we = 1'b0;
      case (mode)
         HOLD:  nxt = r;
         SHL:   begin nxt = {r[WIDTH-2:0], sl};       msb_we = 1'b1; end
         SHR:   begin nxt = {sr, r[WIDTH-1:1]};       lsb_we = 1'b1; end
         ROL:   begin nxt = {r[WIDTH-2:0], r[WIDTH-1]}; msb_we = 1'b1; end
         ROR:   begin nxt = {r[0], r[WIDTH-1:1]};     lsb_we = 1'b1; end
         LOAD:  nxt = load;
         ASR:   begin nxt = {r[WIDTH-1], r[WIDTH-1:1]}; lsb_we = 1'b1; end
         CLEAR: nxt = '0;
         default: nxt = r;
      endcase
   end

endmodule

// File: rtl/univ_shift_reg.sv
// Universal shift register with single-step operation and a counted burst engine.
// state   | meaning
// S_IDLE  | single steps via en_i; start_i launches a burst
// S_BURST | one latched-mode shift per cycle until count reaches zero
module univ_shift_reg
   import usr_pkg::*;
#(
   parameter  int WIDTH = 8,
   localparam int CNT_W = $clog2(WIDTH) + 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en_i,
   input  logic [2:0]       mode_i,
   input  logic             sl_i,
   input  logic             sr_i,
   input  logic [WIDTH-1:0] load_i,
   input  logic             start_i,
   input  logic [CNT_W-1:0] cnt_i,
   output logic [WIDTH-1:0] sr_o,
   output logic             so_msb_o,
   output logic             so_lsb_o,
   output logic             busy_o,
   output logic             done_o
);

   usr_state_e       state;
   shift_mode_e      mode_q;
   logic [CNT_W-1:0] count;
   logic             zero_pend;

   shift_mode_e      mode_in;
   shift_mode_e      cur_mode;
   logic             start_ok;
   logic             act;
   logic [WIDTH-1:0] nxt;
   logic             msb_we;
   logic             lsb_we;

   assign mode_in  = shift_mode_e'(mode_i);
   assign cur_mode = (state == S_BURST) ? mode_q : mode_in;
   assign start_ok = (state == S_IDLE) && start_i && is_shift_mode(mode_in);
   // A zero-length start swallows en_i as well, since start_i wins in IDLE
   assign act      = (state == S_BURST) ||
                     ((state == S_IDLE) && (start_ok ? (cnt_i != '0) : en_i));
   assign busy_o   = (state == S_BURST);

   usr_next_val #(.WIDTH(WIDTH)) u_next (
      .r      (sr_o),
      .mode   (cur_mode),
      .sl     (sl_i),
      .sr     (sr_i),
      .load   (load_i),
      .nxt    (nxt),
      .msb_we (msb_we),
      .lsb_we (lsb_we)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= S_IDLE;
         mode_q    <= HOLD;
         count     <= '0;
         zero_pend <= 1'b0;
         sr_o      <= '0;
         so_msb_o  <= 1'b0;
         so_lsb_o  <= 1'b0;
         done_o    <= 1'b0;
      end else begin
         done_o    <= zero_pend;
         zero_pend <= 1'b0;
         if (act) begin
            sr_o <= nxt;
            if (msb_we) so_msb_o <= sr_o[WIDTH-1];
            if (lsb_we) so_lsb_o <= sr_o[0];
         end
         case (state)
            S_IDLE: begin
               if (start_ok) begin
                  if (cnt_i == '0) begin
                     zero_pend <= 1'b1;
                  end else begin
                     mode_q <= mode_in;
                     count  <= cnt_i - CNT_W'(1);
                     if (cnt_i == CNT_W'(1)) done_o <= 1'b1;
                     else                    state  <= S_BURST;
                  end
               end
            end
            S_BURST: begin
               count <= count - CNT_W'(1);
               if (count == CNT_W'(1)) begin
                  state  <= S_IDLE;
                  done_o <= 1'b1;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_univ_shift_reg.sv
// Directed bench for univ_shift_reg (WIDTH=8): step-vector table plus burst sequences.
module tb_univ_shift_reg;

   localparam int W  = 8;
   localparam int CW = $clog2(W) + 1;

   logic          clk = 1'b0;
   logic          reset;
   logic          en_i;
   logic [2:0]    mode_i;
   logic          sl_i;
   logic          sr_i;
   logic [W-1:0]  load_i;
   logic          start_i;
   logic [CW-1:0] cnt_i;
   logic [W-1:0]  sr_o;
   logic          so_msb_o;
   logic          so_lsb_o;
   logic          busy_o;
   logic          done_o;

   int n_cmp = 0;
   int n_bad = 0;

   univ_shift_reg #(.WIDTH(W)) dut (
      .clk      (clk),
      .reset    (reset),
      .en_i     (en_i),
      .mode_i   (mode_i),
      .sl_i     (sl_i),
      .sr_i     (sr_i),
      .load_i   (load_i),
      .start_i  (start_i),
      .cnt_i    (cnt_i),
      .sr_o     (sr_o),
      .so_msb_o (so_msb_o),
      .so_lsb_o (so_lsb_o),
      .busy_o   (busy_o),
      .done_o   (done_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic         en;
      logic [2:0]   mode;
      logic         sl;
      logic         sr;
      logic [W-1:0] load;
      logic [W-1:0] e_sr;
      logic         e_msb;
      logic         e_lsb;
   } vec_t;

   vec_t vecs[16];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_load(input logic [W-1:0] v);
      en_i = 1'b1; mode_i = 3'b101; load_i = v;
      tick();
      en_i = 1'b0; mode_i = 3'b000;
      chk("load", sr_o, v);
   endtask

   task automatic chk_ctl(input string name, input logic e_busy, input logic e_done);
      chk({name, "_busy"}, busy_o, e_busy);
      chk({name, "_done"}, done_o, e_done);
   endtask

   logic [9:0] sl_stream;

   initial begin
      // en, mode, sl, sr, load, expected sr_o, so_msb_o, so_lsb_o
      vecs[0]  = '{1, 3'b101, 0, 0, 8'h81, 8'h81, 0, 0};
      vecs[1]  = '{1, 3'b001, 0, 0, 8'h00, 8'h02, 1, 0};
      vecs[2]  = '{1, 3'b010, 0, 1, 8'h00, 8'h81, 1, 0};
      vecs[3]  = '{1, 3'b110, 0, 0, 8'h00, 8'hC0, 1, 1};
      vecs[4]  = '{1, 3'b111, 0, 0, 8'h00, 8'h00, 1, 1};
      vecs[5]  = '{1, 3'b000, 1, 1, 8'hFF, 8'h00, 1, 1};
      vecs[6]  = '{1, 3'b101, 0, 0, 8'h3C, 8'h3C, 1, 1};
      vecs[7]  = '{1, 3'b011, 1, 1, 8'h00, 8'h78, 0, 1};
      vecs[8]  = '{1, 3'b100, 1, 1, 8'h00, 8'h3C, 0, 0};
      vecs[9]  = '{0, 3'b101, 0, 0, 8'hFF, 8'h3C, 0, 0};
      vecs[10] = '{1, 3'b001, 1, 0, 8'h00, 8'h79, 0, 0};
      vecs[11] = '{1, 3'b100, 0, 0, 8'h00, 8'hBC, 0, 1};
      vecs[12] = '{1, 3'b110, 0, 1, 8'h00, 8'hDE, 0, 0};
      vecs[13] = '{1, 3'b010, 1, 0, 8'h00, 8'h6F, 0, 0};
      vecs[14] = '{1, 3'b011, 0, 0, 8'h00, 8'hDE, 0, 0};
      vecs[15] = '{1, 3'b011, 0, 0, 8'h00, 8'hBD, 1, 0};
      sl_stream = 10'b1011001011;  // index 9 first

      reset = 1'b1; en_i = 1'b0; mode_i = 3'b000; sl_i = 1'b0; sr_i = 1'b0;
      load_i = '0; start_i = 1'b0; cnt_i = '0;
      tick(); tick();
      chk("rst_sr", sr_o, 8'h00);
      chk("rst_msb", so_msb_o, 1'b0);
      chk("rst_lsb", so_lsb_o, 1'b0);
      chk_ctl("rst", 1'b0, 1'b0);
      #2 reset = 1'b0;

      // single steps from the table
      for (int i = 0; i < 16; i++) begin
         en_i = vecs[i].en; mode_i = vecs[i].mode; sl_i = vecs[i].sl;
         sr_i = vecs[i].sr; load_i = vecs[i].load;
         tick();
         chk($sformatf("vec%0d_sr", i), sr_o, vecs[i].e_sr);
         chk($sformatf("vec%0d_msb", i), so_msb_o, vecs[i].e_msb);
         chk($sformatf("vec%0d_lsb", i), so_lsb_o, vecs[i].e_lsb);
         chk_ctl($sformatf("vec%0d", i), 1'b0, 1'b0);
      end
      en_i = 1'b0; sl_i = 1'b0; sr_i = 1'b0;

      // reset mid-burst
      do_load(8'hA5);
      mode_i = 3'b011; start_i = 1'b1; cnt_i = CW'(5);
      tick();
      start_i = 1'b0;
      chk("rmid_s1", sr_o, 8'h4B);
      chk_ctl("rmid_s1", 1'b1, 1'b0);
      tick();
      chk("rmid_s2", sr_o, 8'h96);
      reset = 1'b1;
      #1;
      chk("rmid_sr", sr_o, 8'h00);
      chk_ctl("rmid", 1'b0, 1'b0);
      tick();
      chk_ctl("rmid_hold", 1'b0, 1'b0);
      #2 reset = 1'b0;
      en_i = 1'b1; mode_i = 3'b000;
      tick();
      en_i = 1'b0;
      chk("rmid_post_sr", sr_o, 8'h00);
      chk_ctl("rmid_post", 1'b0, 1'b0);
      tick();
      chk_ctl("rmid_post2", 1'b0, 1'b0);

      // burst ROR x3, mode toggled mid-burst
      do_load(8'h01);
      mode_i = 3'b100; start_i = 1'b1; cnt_i = CW'(3);
      tick();
      start_i = 1'b0; mode_i = 3'b001;
      chk("ror_e1", sr_o, 8'h80);
      chk_ctl("ror_e1", 1'b1, 1'b0);
      mode_i = 3'b111;
      tick();
      chk("ror_e2", sr_o, 8'h40);
      chk_ctl("ror_e2", 1'b1, 1'b0);
      tick();
      chk("ror_e3", sr_o, 8'h20);
      chk_ctl("ror_e3", 1'b0, 1'b1);
      mode_i = 3'b000;
      tick();
      chk("ror_e4", sr_o, 8'h20);
      chk_ctl("ror_e4", 1'b0, 1'b0);

      // burst SHL x10 with live serial stream
      do_load(8'h00);
      mode_i = 3'b001; start_i = 1'b1; cnt_i = CW'(10);
      for (int k = 0; k < 10; k++) begin
         sl_i = sl_stream[9-k];
         tick();
         start_i = 1'b0; mode_i = 3'b000;
         chk($sformatf("shl10_e%0d", k+1), {busy_o, done_o}, (k == 9) ? 2'b01 : 2'b10);
      end
      sl_i = 1'b0;
      chk("shl10_sr", sr_o, 8'hCB);
      chk("shl10_msb", so_msb_o, 1'b0);
      tick();
      chk_ctl("shl10_after", 1'b0, 1'b0);

      // cnt=0: no shift, done one cycle later
      do_load(8'h5A);
      mode_i = 3'b001; start_i = 1'b1; cnt_i = CW'(0); en_i = 1'b1;
      tick();
      start_i = 1'b0; en_i = 1'b0; mode_i = 3'b000;
      chk("cnt0_e1_sr", sr_o, 8'h5A);
      chk_ctl("cnt0_e1", 1'b0, 1'b0);
      tick();
      chk("cnt0_e2_sr", sr_o, 8'h5A);
      chk_ctl("cnt0_e2", 1'b0, 1'b1);
      tick();
      chk_ctl("cnt0_e3", 1'b0, 1'b0);

      // cnt=1: single shift, done on the start edge
      mode_i = 3'b010; sr_i = 1'b1; start_i = 1'b1; cnt_i = CW'(1);
      tick();
      start_i = 1'b0; mode_i = 3'b000; sr_i = 1'b0;
      chk("cnt1_sr", sr_o, 8'hAD);
      chk("cnt1_lsb", so_lsb_o, 1'b0);
      chk_ctl("cnt1_e1", 1'b0, 1'b1);
      tick();
      chk("cnt1_e2_sr", sr_o, 8'hAD);
      chk_ctl("cnt1_e2", 1'b0, 1'b0);

      // start with a non-shift mode falls back to a plain step
      mode_i = 3'b101; load_i = 8'hC3; en_i = 1'b1; start_i = 1'b1; cnt_i = CW'(3);
      tick();
      start_i = 1'b0; en_i = 1'b0; mode_i = 3'b000;
      chk("ldst_sr", sr_o, 8'hC3);
      chk_ctl("ldst_e1", 1'b0, 1'b0);
      tick();
      chk("ldst_e2_sr", sr_o, 8'hC3);
      chk_ctl("ldst_e2", 1'b0, 1'b0);

      // back-to-back bursts, restart in the done cycle
      do_load(8'h20);
      mode_i = 3'b011; start_i = 1'b1; cnt_i = CW'(2);
      tick();
      start_i = 1'b0;
      chk("b2b_e1", sr_o, 8'h40);
      chk_ctl("b2b_e1", 1'b1, 1'b0);
      tick();
      chk("b2b_e2", sr_o, 8'h80);
      chk_ctl("b2b_e2", 1'b0, 1'b1);
      start_i = 1'b1; cnt_i = CW'(2);
      tick();
      mode_i = 3'b010; cnt_i = CW'(5);
      chk("b2b_e3", sr_o, 8'h01);
      chk_ctl("b2b_e3", 1'b1, 1'b0);
      tick();
      start_i = 1'b0; mode_i = 3'b000;
      chk("b2b_e4", sr_o, 8'h02);
      chk_ctl("b2b_e4", 1'b0, 1'b1);
      tick();
      chk("b2b_e5", sr_o, 8'h02);
      chk_ctl("b2b_e5", 1'b0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
